// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot: MAIN drives the outputs, SKID absorbs
// one extra entry so in_ready can be a pure function of registered state.
module pipe_stage_skid #(
    parameter int DATA_W      = 64,
    parameter int PC_W        = 16,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    input  logic              flush,
    output logic [1:0]        count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and in_ready never looks at same-cycle out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam bit ZB = (ZERO_BUBBLE != 0);

    state_t            state_q, state_next;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [PC_W-1:0]   main_pc, skid_pc;

    logic in_fire, out_fire;
    logic main_load_in, main_load_skid, skid_load, main_clear, flush_clear;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data;
    assign out_pc    = main_pc;
    assign count     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next     = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        main_clear     = 1'b0;
        flush_clear    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    main_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load_in = 1'b1;
                end else if (in_fire) begin
                    state_next = TWO;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                    main_clear = ZB;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_next     = ONE;
                    main_load_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over every same-cycle transfer.
        if (flush) begin
            state_next     = EMPTY;
            main_load_in   = 1'b0;
            main_load_skid = 1'b0;
            skid_load      = 1'b0;
            main_clear     = 1'b0;
            flush_clear    = ZB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_pc   <= '0;
        end else if (flush_clear || main_clear) begin
            main_data <= '0;
            main_pc   <= '0;
        end else if (main_load_in) begin
            main_data <= in_data;
            main_pc   <= in_pc;
        end else if (main_load_skid) begin
            main_data <= skid_data;
            main_pc   <= skid_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= '0;
            skid_pc   <= '0;
        end else if (flush_clear) begin
            skid_data <= '0;
            skid_pc   <= '0;
        end else if (skid_load) begin
            skid_data <= in_data;
            skid_pc   <= in_pc;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a long random run checked
// against a FIFO-of-depth-two queue model.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int PC_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              flush = 1'b0;
    logic [1:0]        count;

    int errors = 0;
    int checks = 0;

    // Model entries are {pc, data}.
    logic [PC_W+DATA_W-1:0] exp_q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .PC_W(PC_W), .ZERO_BUBBLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_pc     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b data=%h pc=%h, want 0 0 1 0 0",
                     count, out_valid, in_ready, out_data, out_pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 64'hA; in_pc = 16'h10; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hA || out_pc !== 16'h10 || count !== 2'd1) begin
            errors++;
            $display("FAIL single_latency: valid=%b data=%h pc=%h count=%0d, want 1 a 10 1",
                     out_valid, out_data, out_pc, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL single_drain: valid=%b count=%0d data=%h pc=%h, want 0 0 0 0",
                     out_valid, count, out_data, out_pc);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h1; in_pc = 16'h101;
        tick();
        in_data = 64'h2; in_pc = 16'h102;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'h1 || out_pc !== 16'h101) begin
                errors++;
                $display("FAIL stall_hold[%0d]: count=%0d in_ready=%b data=%h pc=%h, want 2 0 1 101",
                         i, count, in_ready, out_data, out_pc);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h2 || out_pc !== 16'h102 || count !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: valid=%b data=%h pc=%h count=%0d, want 1 2 102 1",
                     out_valid, out_data, out_pc, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL stall_empty: valid=%b count=%0d, want 0 0", out_valid, count);
        end
        idle_inputs();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_pc = 16'(16'h200 + i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(i) || out_pc !== 16'(16'h200 + i) ||
                count !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b data=%h pc=%h count=%0d in_ready=%b, want 1 %h %h 1 1",
                         i, out_valid, out_data, out_pc, count, in_ready, i, 16'h200 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: count=%0d, want 0", count);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h3; in_pc = 16'h33;
        tick();
        in_data = 64'h4; in_pc = 16'h44;
        tick();
        in_data = 64'h9; in_pc = 16'h99; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_pc !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: count=%0d valid=%b data=%h pc=%h in_ready=%b, want 0 0 0 0 1",
                     count, out_valid, out_data, out_pc, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data === 64'h9) begin
            errors++;
            $display("FAIL flush_no_ghost: valid=%b data=%h, want 0 and not 9", out_valid, out_data);
        end
        // Flush in ONE with a same-cycle accepted entry and head consumption.
        in_valid = 1'b1; in_data = 64'h5; in_pc = 16'h55;
        tick();
        in_data = 64'h6; in_pc = 16'h66; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL flush_one_fire: count=%0d valid=%b data=%h pc=%h, want 0 0 0 0",
                     count, out_valid, out_data, out_pc);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h7; in_pc = 16'h77;
        tick();
        in_data = 64'h8; in_pc = 16'h88;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin
            errors++;
            $display("FAIL async_prefill: count=%0d, want 2", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1 || out_data !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d in_ready=%b data=%h pc=%h, want 0 0 1 0 0",
                     out_valid, count, in_ready, out_data, out_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 64'hC; in_pc = 16'hCC;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hC || out_pc !== 16'hCC || count !== 2'd1) begin
            errors++;
            $display("FAIL async_first_accept: valid=%b data=%h pc=%h count=%0d, want 1 c cc 1",
                     out_valid, out_data, out_pc, count);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic                   rdy_a;
        logic                   m_in_ready, m_out_valid;
        logic [PC_W+DATA_W-1:0] head;
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            checks++;
            if (count !== 2'(exp_q.size()) || out_valid !== (exp_q.size() > 0) ||
                in_ready !== (exp_q.size() < 2) || {out_pc, out_data} !== head) begin
                errors++;
                $display("FAIL random_state@%0d: count=%0d valid=%b in_ready=%b pc=%h data=%h, want %0d %b %b %h %h",
                         cyc, count, out_valid, in_ready, out_pc, out_data, exp_q.size(),
                         exp_q.size() > 0, exp_q.size() < 2, head[PC_W+DATA_W-1:DATA_W], head[DATA_W-1:0]);
            end
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = {$urandom, $urandom};
            in_pc    = 16'($urandom);
            flush    = ($urandom_range(0, 99) < 4);
            rdy_a    = ($urandom_range(0, 1) == 1);
            out_ready = rdy_a;
            #1;
            out_ready = ~rdy_a;
            #1;
            checks++;
            if (in_ready !== (exp_q.size() < 2)) begin
                errors++;
                $display("FAIL random_ready_path@%0d: in_ready=%b, want %b", cyc, in_ready, exp_q.size() < 2);
            end
            out_ready = ($urandom_range(0, 99) < 55);
            m_in_ready  = (exp_q.size() < 2);
            m_out_valid = (exp_q.size() > 0);
            @(posedge clk);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_out_valid && out_ready) void'(exp_q.pop_front());
                if (in_valid && m_in_ready) exp_q.push_back({in_pc, in_data});
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_stall();
        test_stream();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
